// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze FSM, data-hazard bubbles,
// branch flushes, and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MEM_WAIT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic        use_src1,
    input  logic        use_src2,
    input  logic [3:0]  exe_dest,
    input  logic        exe_wb_en,
    input  logic        exe_mem_r_en,
    input  logic [3:0]  mem_dest,
    input  logic        mem_wb_en,
    input  logic        mem_access,
    input  logic        fwd_en,
    input  logic        branch_taken,
    output logic        pc_freeze,
    output logic        id_freeze,
    output logic        pipe_freeze,
    output logic        if_flush,
    output logic        id_flush,
    output logic        mem_busy,
    output logic [15:0] stall_count
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_q, stall_d;
    logic        mem_freeze;
    logic        hazard;
    logic        hz_exe1, hz_exe2, hz_mem1, hz_mem2;

    assign hz_exe1 = use_src1 && exe_wb_en && (src1 == exe_dest);
    assign hz_exe2 = use_src2 && exe_wb_en && (src2 == exe_dest);
    assign hz_mem1 = use_src1 && mem_wb_en && (src1 == mem_dest);
    assign hz_mem2 = use_src2 && mem_wb_en && (src2 == mem_dest);

    // With forwarding only a load feeding the next instruction must stall.
    always_comb begin
        if (fwd_en)
            hazard = exe_mem_r_en && (hz_exe1 || hz_exe2);
        else
            hazard = hz_exe1 || hz_exe2 || hz_mem1 || hz_mem2;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_freeze = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_access) begin
                    mem_freeze = 1'b1;
                    state_d    = WAIT;
                    cnt_d      = 4'(MEM_WAIT - 1);
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    mem_freeze = 1'b1;
                    cnt_d      = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_freeze   = 1'b0;
        id_freeze   = 1'b0;
        pipe_freeze = 1'b0;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        if (rst) begin
            pc_freeze = 1'b0;
        end else if (mem_freeze) begin
            pc_freeze   = 1'b1;
            id_freeze   = 1'b1;
            pipe_freeze = 1'b1;
        end else if (branch_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (hazard) begin
            pc_freeze = 1'b1;
            id_flush  = 1'b1;
        end
    end

    assign stall_d     = (pc_freeze && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    assign mem_busy    = !rst && (state_q == WAIT);
    assign stall_count = stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; outputs checked as {pc,id_frz,pipe,if_fl,id_fl}.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src1, src2, exe_dest, mem_dest;
    logic        use_src1, use_src2, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic        mem_access, fwd_en, branch_taken;
    logic        pc_freeze, id_freeze, pipe_freeze, if_flush, id_flush, mem_busy;
    logic [15:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [4:0] O_NONE = 5'b00000;
    localparam logic [4:0] O_MEM  = 5'b11100;
    localparam logic [4:0] O_BR   = 5'b00011;
    localparam logic [4:0] O_HZ   = 5'b10001;

    hazard_ctrl #(.MEM_WAIT(5)) dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2),
        .use_src1(use_src1), .use_src2(use_src2),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
        .fwd_en(fwd_en), .branch_taken(branch_taken),
        .pc_freeze(pc_freeze), .id_freeze(id_freeze), .pipe_freeze(pipe_freeze),
        .if_flush(if_flush), .id_flush(id_flush), .mem_busy(mem_busy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    wire [4:0] outs = {pc_freeze, id_freeze, pipe_freeze, if_flush, id_flush};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change just after the edge, checks follow #2.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        src1 = 4'd0; src2 = 4'd0; use_src1 = 0; use_src2 = 0;
        exe_dest = 4'd0; exe_wb_en = 0; exe_mem_r_en = 0;
        mem_dest = 4'd0; mem_wb_en = 0; mem_access = 0;
        fwd_en = 0; branch_taken = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        clr_in();
        // Reset with every request active: outputs must stay quiet.
        rst = 1'b1;
        mem_access = 1; use_src1 = 1; exe_wb_en = 1; src1 = 4'd3; exe_dest = 4'd3;
        #2;
        chk("rst_outs", 32'(outs), 32'(O_NONE));
        chk("rst_busy", 32'(mem_busy), 32'd0);
        cyc();
        #2;
        chk("rst_stall", 32'(stall_count), 32'd0);
        clr_in();
        rst = 1'b0;

        // No-forwarding RAW on EXE dest via src1.
        fwd_en = 0; exe_wb_en = 1; exe_dest = 4'd3; src1 = 4'd3; use_src1 = 1;
        #2; chk("nofwd_exe_src1", 32'(outs), 32'(O_HZ));
        use_src1 = 0;
        #1; chk("nofwd_unused", 32'(outs), 32'(O_NONE));
        clr_in();
        mem_wb_en = 1; mem_dest = 4'd9; src2 = 4'd9; use_src2 = 1;
        #1; chk("nofwd_mem_src2", 32'(outs), 32'(O_HZ));
        fwd_en = 1;
        #1; chk("fwd_mem_src2", 32'(outs), 32'(O_NONE));
        clr_in();

        // Load-use with forwarding.
        cyc();
        fwd_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd7; src2 = 4'd7; use_src2 = 1;
        #2; chk("loaduse", 32'(outs), 32'(O_HZ));
        exe_mem_r_en = 0;
        #1; chk("fwd_alu", 32'(outs), 32'(O_NONE));
        exe_mem_r_en = 1; branch_taken = 1;
        #1; chk("branch_over_hz", 32'(outs), 32'(O_BR));
        clr_in();

        // Single memory access, MEM_WAIT=5.
        do_reset();
        mem_access = 1;
        #2; chk("mem_c1", 32'(outs), 32'(O_MEM));
        chk("mem_c1_busy", 32'(mem_busy), 32'd0);
        for (int c = 2; c <= 5; c++) begin
            cyc();
            if (c == 3) begin
                branch_taken = 1; fwd_en = 0; use_src1 = 1; exe_wb_en = 1;
                src1 = 4'd2; exe_dest = 4'd2;
            end else begin
                branch_taken = 0; use_src1 = 0;
            end
            #2;
            chk($sformatf("mem_c%0d", c), 32'(outs), 32'(O_MEM));
            chk($sformatf("mem_c%0d_busy", c), 32'(mem_busy), 32'd1);
        end
        cyc();
        #2;
        chk("mem_c6", 32'(outs), 32'(O_NONE));
        chk("mem_c6_busy", 32'(mem_busy), 32'd1);
        cyc();
        #2;
        chk("mem_b2b_c1", 32'(outs), 32'(O_MEM));
        chk("mem_b2b_busy", 32'(mem_busy), 32'd0);
        chk("mem_stall5", 32'(stall_count), 32'd5);

        // Abort a wait with cnt=2 (second access: c1 load 4, c2=4, c3=3, c4=2).
        cyc(); cyc(); cyc();
        #2;
        chk("abort_pre_busy", 32'(mem_busy), 32'd1);
        rst = 1;
        #1;
        chk("abort_rst_outs", 32'(outs), 32'(O_NONE));
        chk("abort_rst_busy", 32'(mem_busy), 32'd0);
        cyc();
        rst = 0; mem_access = 0;
        #2;
        chk("abort_busy", 32'(mem_busy), 32'd0);
        chk("abort_stall", 32'(stall_count), 32'd0);
        chk("abort_outs", 32'(outs), 32'(O_NONE));
        mem_access = 1;
        #1;
        chk("fresh_req", 32'(outs), 32'(O_MEM));
        clr_in();

        // Stall counter saturation.
        do_reset();
        fwd_en = 0; use_src1 = 1; exe_wb_en = 1; src1 = 4'd5; exe_dest = 4'd5;
        for (int i = 0; i < 65540; i++) cyc();
        #2;
        chk("stall_sat", 32'(stall_count), 32'hFFFF);
        cyc();
        #2;
        chk("stall_hold", 32'(stall_count), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 5, SHALL set the number of full-pipeline freeze cycles per memory access; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 src1, src2  in  4 each  ID-stage source register numbers.
REQ-005 use_src1, use_src2  in  1 each  ID instruction reads src1 / src2.
REQ-006 exe_dest  in  4; exe_wb_en  in  1; exe_mem_r_en  in  1  ID/EX register outputs (EXE-stage instruction).
REQ-007 mem_dest  in  4; mem_wb_en  in  1  EX/MEM register outputs.
REQ-008 mem_access  in  1  MEM-stage instruction has Mem_R_EN or Mem_W_EN set.
REQ-009 fwd_en  in  1  forwarding unit enabled.
REQ-010 branch_taken  in  1  EXE-stage B asserted.
REQ-011 pc_freeze  out  1  hold PC and IF/ID register.
REQ-012 id_freeze  out  1  drives ID/EX register freeze.
REQ-013 pipe_freeze  out  1  hold EX/MEM and MEM/WB registers.
REQ-014 if_flush  out  1  clear IF/ID register.
REQ-015 id_flush  out  1  drives ID/EX register flush.
REQ-016 mem_busy  out  1  memory-wait FSM not in IDLE.
REQ-017 stall_count  out  16  cycles with pc_freeze=1 since reset.

Function
REQ-018 Data hazard (fwd_en=0) SHALL be: (use_src1 and ((exe_wb_en and src1==exe_dest) or (mem_wb_en and src1==mem_dest))) or the same term for src2/use_src2.
REQ-019 Data hazard (fwd_en=1) SHALL be load-use only: exe_mem_r_en and exe_wb_en and ((use_src1 and src1==exe_dest) or (use_src2 and src2==exe_dest)).
REQ-020 Memory FSM states: IDLE, WAIT; 4-bit counter cnt.
REQ-021 IDLE with mem_access=1 SHALL assert mem freeze that cycle, go to WAIT, load cnt=MEM_WAIT-1.
REQ-022 WAIT with cnt!=0 SHALL assert mem freeze and decrement cnt; WAIT with cnt==0 SHALL deassert mem freeze and return to IDLE.
REQ-023 Result: each memory instruction SHALL see exactly MEM_WAIT frozen cycles followed by one unfrozen cycle; mem_access in WAIT is ignored (same instruction).
REQ-024 Back-to-back memory instructions SHALL each start a new wait from the IDLE cycle following the unfrozen cycle.
REQ-025 Priority 1 (mem freeze): pc_freeze=id_freeze=pipe_freeze=1, if_flush=id_flush=0, regardless of hazard or branch_taken.
REQ-026 Priority 2 (branch_taken, no mem freeze): if_flush=id_flush=1, pc_freeze=0, freezes 0; a coincident data hazard SHALL be ignored.
REQ-027 Priority 3 (data hazard only): pc_freeze=1, id_flush=1 (bubble), id_freeze=pipe_freeze=if_flush=0.
REQ-028 Otherwise all freeze/flush outputs SHALL be 0.
REQ-029 Freeze/flush outputs SHALL be combinational from FSM state, cnt and current inputs (no added latency).
REQ-030 stall_count SHALL increment by 1 on each rising edge where pc_freeze=1 and SHALL saturate at 16'hFFFF.
REQ-031 mem_busy SHALL be 1 exactly when state is WAIT.

Reset
REQ-032 rst=1 at a rising edge SHALL set state=IDLE, cnt=0, stall_count=0, including mid-WAIT (wait aborted).
REQ-033 While rst=1, all freeze/flush outputs and mem_busy SHALL be 0.
REQ-034 First cycle after rst deasserts SHALL evaluate mem_access as a fresh IDLE request.

Verification
REQ-035 MEM_WAIT=5, mem_access=1 for one instruction -> pipe_freeze=1 for 5 consecutive cycles, 0 on 6th; mem_busy=1 on cycles 2-6; stall_count=5.
REQ-036 fwd_en=0, exe_wb_en=1, exe_dest=4'd3, src1=4'd3, use_src1=1 -> pc_freeze=1, id_flush=1, id_freeze=0; use_src1=0 -> all 0.
REQ-037 fwd_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=src2=4'd7, use_src2=1 -> pc_freeze=id_flush=1; exe_mem_r_en=0 -> all 0.
REQ-038 branch_taken=1 with concurrent data hazard -> if_flush=id_flush=1, pc_freeze=0; same during WAIT -> flushes 0, all freezes 1.
REQ-039 rst=1 asserted with cnt=2 in WAIT -> next cycle state IDLE, mem_busy=0, stall_count=0, outputs 0.
REQ-040 Force 65540 hazard cycles -> stall_count holds 16'hFFFF.
